// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
//   psc_state_e           : sequencer states (RUN, MEM_WAIT, SWP_SECOND)
//   PSC_MEM_TIMEOUT_DEF   : default SRAM wait limit before mem_error
//   PSC_CNT_W_DEF         : default performance counter width
package pipeline_stall_controller_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    MEM_WAIT   = 2'd1,
    SWP_SECOND = 2'd2
  } psc_state_e;

  localparam int PSC_MEM_TIMEOUT_DEF = 64;
  localparam int PSC_CNT_W_DEF       = 32;

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Control bundle between the pipeline (hazard unit, EXE, MEM stage) and the
// stall sequencer.
//   master : drives hazard/branch/SWP/SRAM status, receives freeze/flush controls
//   slave  : the sequencer itself
interface pipeline_stall_controller_if;
  logic hazard_detected;
  logic branch_taken;
  logic id_is_swp;
  logic mem_req;
  logic sram_ready;
  logic freeze_pc;
  logic freeze_if_id;
  logic flush_if_id;
  logic bubble_id_exe;
  logic freeze_all;
  logic swp_phase;
  logic mem_error;

  modport master (
    output hazard_detected, branch_taken, id_is_swp, mem_req, sram_ready,
    input  freeze_pc, freeze_if_id, flush_if_id, bubble_id_exe, freeze_all,
           swp_phase, mem_error
  );

  modport slave (
    input  hazard_detected, branch_taken, id_is_swp, mem_req, sram_ready,
    output freeze_pc, freeze_if_id, flush_if_id, bubble_id_exe, freeze_all,
           swp_phase, mem_error
  );
endinterface

// File: rtl/pipeline_stall_controller_timeout.sv
// psc_timeout_counter: counts consecutive enabled cycles and pulses expired
// in the cycle that brings the count to LIMIT. Saturates at LIMIT so the
// pulse fires once per wait episode.
//   clk, rst  : clock, async active-low reset
//   clear     : zero the count (takes priority over enable)
//   enable    : count this cycle
//   expired   : this cycle is the LIMIT-th consecutive enabled cycle
module psc_timeout_counter #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && cnt_q != W'(LIMIT)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign expired = enable & ~clear & (cnt_q == W'(LIMIT - 1));
endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline. Merges hazard,
// branch, SRAM wait and two-phase SWP into per-stage freeze/flush controls.
// Controls are combinational from state + inputs (same-cycle effect) and are
// forced low while rst is asserted.
//   clk, rst : pipeline clock, async active-low reset
//   psc      : control bundle (slave side)
//   hazard_cnt, mem_stall_cnt, flush_cnt : perf counters, present only when
//              PSC_PERF_CNT_EN is defined
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = PSC_MEM_TIMEOUT_DEF,
  parameter int CNT_W       = PSC_CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  pipeline_stall_controller_if.slave psc
`ifdef PSC_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] hazard_cnt,
  output logic [CNT_W-1:0] mem_stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);
  if (MEM_TIMEOUT < 2 || CNT_W < 1) begin : g_bad_cfg
    $error("pipeline_stall_controller: MEM_TIMEOUT must be >= 2 and CNT_W >= 1");
  end

  psc_state_e state_q, state_d, ret_q, ret_d, eff_state;
  logic       mem_error_q, mem_error_d;
  logic       wait_mem, expired;
  logic       hazard_stall, branch_flush;
  logic       fpc, fifid, flush, bubble, fall, phase;

  assign wait_mem = psc.mem_req & ~psc.sram_ready;

  always_comb begin
    fpc          = 1'b0;
    fifid        = 1'b0;
    flush        = 1'b0;
    bubble       = 1'b0;
    fall         = 1'b0;
    phase        = 1'b0;
    hazard_stall = 1'b0;
    branch_flush = 1'b0;
    state_d      = state_q;
    ret_d        = ret_q;
    // In the sram_ready cycle the pipeline acts as if already back in the
    // saved state, so a held branch or pending SWP phase 1 executes there.
    eff_state    = (state_q == MEM_WAIT) ? ret_q : state_q;

    if (wait_mem) begin
      fall    = 1'b1;
      state_d = MEM_WAIT;
      if (state_q != MEM_WAIT) ret_d = state_q;
    end else if (psc.branch_taken) begin
      flush        = 1'b1;
      bubble       = 1'b1;
      branch_flush = 1'b1;
      state_d      = RUN;
    end else if (psc.hazard_detected && !psc.id_is_swp) begin
      fpc          = 1'b1;
      fifid        = 1'b1;
      bubble       = 1'b1;
      hazard_stall = 1'b1;
      state_d      = eff_state;
    end else if (psc.id_is_swp && eff_state == RUN) begin
      fpc     = 1'b1;
      fifid   = 1'b1;
      state_d = SWP_SECOND;
    end else if (eff_state == SWP_SECOND) begin
      phase   = 1'b1;
      state_d = RUN;
    end else begin
      state_d = RUN;
    end
  end

  psc_timeout_counter #(.LIMIT(MEM_TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (~wait_mem),
    .enable  (wait_mem),
    .expired (expired)
  );

  assign mem_error_d = mem_error_q | expired;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      ret_q       <= RUN;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      mem_error_q <= mem_error_d;
    end
  end

  assign psc.freeze_pc     = fpc & rst;
  assign psc.freeze_if_id  = fifid & rst;
  assign psc.flush_if_id   = flush & rst;
  assign psc.bubble_id_exe = bubble & rst;
  assign psc.freeze_all    = fall & rst;
  assign psc.swp_phase     = phase & rst;
  assign psc.mem_error     = mem_error_q;

`ifdef PSC_PERF_CNT_EN
  logic [CNT_W-1:0] hazard_cnt_q, hazard_cnt_d;
  logic [CNT_W-1:0] mem_stall_cnt_q, mem_stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    hazard_cnt_d    = hazard_cnt_q + CNT_W'(hazard_stall);
    mem_stall_cnt_d = mem_stall_cnt_q + CNT_W'(fall);
    flush_cnt_d     = flush_cnt_q + CNT_W'(branch_flush);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hazard_cnt_q    <= '0;
      mem_stall_cnt_q <= '0;
      flush_cnt_q     <= '0;
    end else begin
      hazard_cnt_q    <= hazard_cnt_d;
      mem_stall_cnt_q <= mem_stall_cnt_d;
      flush_cnt_q     <= flush_cnt_d;
    end
  end

  assign hazard_cnt    = hazard_cnt_q;
  assign mem_stall_cnt = mem_stall_cnt_q;
  assign flush_cnt     = flush_cnt_q;
`endif
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench for pipeline_stall_controller. Each stimulus row is
// {hazard, branch, swp, mem_req, sram_ready, expected 7-bit outputs}; the
// output vector is {freeze_pc, freeze_if_id, flush_if_id, bubble_id_exe,
// freeze_all, swp_phase, mem_error}.
module tb_pipeline_stall_controller;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  logic [6:0] exp_q [$];

  pipeline_stall_controller_if psc_if ();

`ifdef PSC_PERF_CNT_EN
  logic [CNT_W-1:0] hazard_cnt, mem_stall_cnt, flush_cnt;
`endif

  pipeline_stall_controller #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .psc (psc_if)
`ifdef PSC_PERF_CNT_EN
    ,
    .hazard_cnt    (hazard_cnt),
    .mem_stall_cnt (mem_stall_cnt),
    .flush_cnt     (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] outs();
    return {psc_if.freeze_pc, psc_if.freeze_if_id, psc_if.flush_if_id,
            psc_if.bubble_id_exe, psc_if.freeze_all, psc_if.swp_phase,
            psc_if.mem_error};
  endfunction

  task automatic set_in(input logic [4:0] v);
    psc_if.hazard_detected = v[4];
    psc_if.branch_taken    = v[3];
    psc_if.id_is_swp       = v[2];
    psc_if.mem_req         = v[1];
    psc_if.sram_ready      = v[0];
  endtask

  task automatic drive(input logic [11:0] row);
    @(posedge clk);
    #1;
    set_in(row[11:7]);
    exp_q.push_back(row[6:0]);
  endtask

  task automatic test_reset();
    logic [6:0] exp_v;
    set_in(5'b10010);
    exp_q.push_back(7'b0000000);
    #2;
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (outs() !== exp_v) begin
      n_fail++;
      $display("FAIL reset_outs got %b want %b", outs(), exp_v);
    end
`ifdef PSC_PERF_CNT_EN
    n_cmp++;
    if ({hazard_cnt, mem_stall_cnt, flush_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_cnt got %0d/%0d/%0d want 0", hazard_cnt, mem_stall_cnt, flush_cnt);
    end
`endif
    set_in(5'b00000);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_hazard();
    logic [11:0] tbl [3];
    logic [6:0]  exp_v;
    tbl = '{{5'b10000, 7'b1101000}, {5'b10000, 7'b1101000}, {5'b00000, 7'b0000000}};
    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (outs() !== exp_v) begin
        n_fail++;
        $display("FAIL hazard[%0d] got %b want %b", i, outs(), exp_v);
      end
    end
  endtask

  task automatic test_swp_hazard();
    logic [11:0] tbl [5];
    logic [6:0]  exp_v;
    tbl = '{{5'b10100, 7'b1100000}, {5'b10100, 7'b0000010},
            {5'b00100, 7'b1100000}, {5'b00100, 7'b0000010},
            {5'b00000, 7'b0000000}};
    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (outs() !== exp_v) begin
        n_fail++;
        $display("FAIL swp_hazard[%0d] got %b want %b", i, outs(), exp_v);
      end
    end
  endtask

  task automatic test_mem_wait();
    logic [11:0] tbl [5];
    logic [6:0]  exp_v;
`ifdef PSC_PERF_CNT_EN
    logic [CNT_W-1:0] base = mem_stall_cnt;
`endif
    tbl = '{{5'b00010, 7'b0000100}, {5'b00010, 7'b0000100}, {5'b00010, 7'b0000100},
            {5'b00011, 7'b0000000}, {5'b00000, 7'b0000000}};
    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (outs() !== exp_v) begin
        n_fail++;
        $display("FAIL mem_wait[%0d] got %b want %b", i, outs(), exp_v);
      end
    end
`ifdef PSC_PERF_CNT_EN
    n_cmp++;
    if (mem_stall_cnt !== base + CNT_W'(3)) begin
      n_fail++;
      $display("FAIL mem_stall_cnt got %0d want %0d", mem_stall_cnt, base + CNT_W'(3));
    end
`endif
  endtask

  task automatic test_branch();
    logic [11:0] tbl [5];
    logic [6:0]  exp_v;
`ifdef PSC_PERF_CNT_EN
    logic [CNT_W-1:0] base = flush_cnt;
`endif
    // branch+hazard, then branch held through an SRAM wait
    tbl = '{{5'b11000, 7'b0011000}, {5'b00000, 7'b0000000},
            {5'b01010, 7'b0000100}, {5'b01011, 7'b0011000},
            {5'b00000, 7'b0000000}};
    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (outs() !== exp_v) begin
        n_fail++;
        $display("FAIL branch[%0d] got %b want %b", i, outs(), exp_v);
      end
    end
`ifdef PSC_PERF_CNT_EN
    n_cmp++;
    if (flush_cnt !== base + CNT_W'(2)) begin
      n_fail++;
      $display("FAIL flush_cnt got %0d want %0d", flush_cnt, base + CNT_W'(2));
    end
`endif
  endtask

  task automatic test_swp_mem();
    logic [11:0] tbl [7];
    logic [6:0]  exp_v;
    tbl = '{{5'b00100, 7'b1100000}, {5'b00110, 7'b0000100},
            {5'b00110, 7'b0000100}, {5'b00111, 7'b0000010},
            {5'b00000, 7'b0000000}, {5'b00100, 7'b1100000},
            {5'b00000, 7'b0000010}};
    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (outs() !== exp_v) begin
        n_fail++;
        $display("FAIL swp_mem[%0d] got %b want %b", i, outs(), exp_v);
      end
    end
  endtask

  task automatic test_timeout();
    logic [11:0] tbl [9];
    logic [6:0]  exp_v;
    tbl = '{{5'b00000, 7'b0000000},
            {5'b00010, 7'b0000100}, {5'b00010, 7'b0000100},
            {5'b00010, 7'b0000100}, {5'b00010, 7'b0000100},
            {5'b00010, 7'b0000101}, {5'b00010, 7'b0000101},
            {5'b00011, 7'b0000001}, {5'b00000, 7'b0000001}};
    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (outs() !== exp_v) begin
        n_fail++;
        $display("FAIL timeout[%0d] got %b want %b", i, outs(), exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_swp();
    logic [11:0] pre [2];
    logic [11:0] post [3];
    logic [6:0]  exp_v;
    pre  = '{{5'b00100, 7'b1100001}, {5'b00110, 7'b0000101}};
    post = '{{5'b00100, 7'b1100000}, {5'b00100, 7'b0000010}, {5'b00000, 7'b0000000}};
    foreach (pre[i]) begin
      drive(pre[i]);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (outs() !== exp_v) begin
        n_fail++;
        $display("FAIL rst_mid_pre[%0d] got %b want %b", i, outs(), exp_v);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.push_back(7'b0000000);
    #1;
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (outs() !== exp_v) begin
      n_fail++;
      $display("FAIL rst_mid_async got %b want %b", outs(), exp_v);
    end
    @(negedge clk);
    set_in(5'b00000);
    rst = 1'b1;
    foreach (post[i]) begin
      drive(post[i]);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (outs() !== exp_v) begin
        n_fail++;
        $display("FAIL rst_mid_post[%0d] got %b want %b", i, outs(), exp_v);
      end
    end
  endtask

  initial begin
    set_in(5'b00000);
    test_reset();
    test_hazard();
    test_swp_hazard();
    test_mem_wait();
    test_branch();
    test_swp_mem();
    test_timeout();
    test_reset_mid_swp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
